// File: rtl/arb_rr4_pkg.sv
// Shared types, sizes and the round-robin search used by the four-way arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } win_t;

  // First requester in the order last+1, last+2, last+3, last (mod 4).
  function automatic win_t next_winner(input logic [NUM_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   last);
    win_t             w;
    logic [IDX_W-1:0] k;
    w = '0;
    // Walk from lowest priority to highest so the highest-priority hit is kept.
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = last + IDX_W'(i);
      if (req[k]) begin
        w.found = 1'b1;
        w.idx   = k;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_rr4_if.sv
// Request/grant bundle between the clients (master) and the arbiter (slave).
interface arb_rr4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;

  modport master (output req, input gnt, input gnt_idx, input gnt_vld);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_vld);
endinterface

// File: rtl/arb_rr4_dec2to4.sv
// Enabled 2-to-4 one-hot decoder.
module dec2to4
  import arb_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] y_c
);

  always_comb begin
    y_c = '0;
    if (en) y_c[idx] = 1'b1;
  end

endmodule

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with a hold limit that forces rotation
// only while other clients are waiting.
module arb_rr4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
)(
  input  logic      clk,
  input  logic      rst,
  arb_rr4_if.slave  bus
);

  localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit          HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = HOLD_EN ? CW'(MAX_HOLD - 1) : '0;

  state_e             state_q, state_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;
  logic [IDX_W-1:0]   last_q, last_nx;
  logic               vld_q, vld_nx;
  logic [CW-1:0]      cnt_q, cnt_nx;
  logic [NUM_REQ-1:0] own_mask;
  logic [NUM_REQ-1:0] gnt_c;
  win_t               win_any, win_oth;

  // Winner for a fresh grant/release, and one that skips the current owner.
  always_comb begin
    own_mask = NUM_REQ'(1) << idx_q;
    win_any  = next_winner(bus.req, last_q);
    win_oth  = next_winner(bus.req & ~own_mask, last_q);
  end

  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    last_nx  = last_q;
    vld_nx   = vld_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_any.found) begin
          state_nx = GRANT;
          idx_nx   = win_any.idx;
          last_nx  = win_any.idx;
          vld_nx   = 1'b1;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (bus.req[idx_q]) begin
          if (HOLD_EN && (cnt_q == HOLD_LAST) && win_oth.found) begin
            idx_nx  = win_oth.idx;
            last_nx = win_oth.idx;
            cnt_nx  = '0;
          end else if (HOLD_EN && (cnt_q != HOLD_LAST)) begin
            cnt_nx = cnt_q + CW'(1);
          end
        end else if (win_any.found) begin
          // Owner's bit is low, so the plain search already excludes it.
          idx_nx  = win_any.idx;
          last_nx = win_any.idx;
          cnt_nx  = '0;
        end else begin
          state_nx = IDLE;
          vld_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        vld_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      last_q  <= last_nx;
      vld_q   <= vld_nx;
      cnt_q   <= cnt_nx;
    end
  end

  dec2to4 u_dec (
    .en  (vld_q),
    .idx (idx_q),
    .y_c (gnt_c)
  );

  assign bus.gnt     = gnt_c;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;

endmodule

// File: tb/tb_arb_rr4.sv
// Scoreboard bench for arb_rr4: expectations queued as requests are driven,
// popped and compared one time unit after the following rising edge.
module tb_arb_rr4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } exp_t;

  logic clk;
  logic rst;
  arb_rr4_if bus ();

  arb_rr4 #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  sb[$];
  string sb_name[$];
  int    tests = 0;
  int    fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [3:0] g, input logic [1:0] i, input logic v, input string n);
    exp_t e;
    e.gnt = g; e.idx = i; e.vld = v;
    sb.push_back(e);
    sb_name.push_back(n);
  endtask

  task automatic reset_dut();
    bus.req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e; string n;
    rst = 1'b1;
    bus.req = 4'b0000;
    push(4'b0000, 2'd0, 1'b0, "reset_state");
    #1;
    e = sb.pop_front(); n = sb_name.pop_front();
    tests++;
    if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
      fails++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
               n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
    end
    reset_dut();
  endtask

  task automatic test_basic_handover();
    logic [3:0] r [3];
    logic [3:0] g [3];
    logic [1:0] x [3];
    logic       v [3];
    exp_t e; string n;
    r[0] = 4'b0101; g[0] = 4'b0001; x[0] = 2'd0; v[0] = 1'b1;
    r[1] = 4'b0100; g[1] = 4'b0100; x[1] = 2'd2; v[1] = 1'b1;
    r[2] = 4'b0000; g[2] = 4'b0000; x[2] = 2'd2; v[2] = 1'b0;
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req = r[k];
      push(g[k], x[k], v[k], $sformatf("handover_step%0d", k));
      @(posedge clk); #1;
      e = sb.pop_front(); n = sb_name.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
        fails++;
        $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                 n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e; string n;
    int owner;
    reset_dut();
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      bus.req = 4'b1111;
      owner = (c / 8) % 4;
      push(4'b0001 << owner, 2'(owner), 1'b1, $sformatf("rotate_cycle%0d", c));
      @(posedge clk); #1;
      e = sb.pop_front(); n = sb_name.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
        fails++;
        $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                 n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_single_requester();
    exp_t e; string n;
    reset_dut();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.req = 4'b0010;
      push(4'b0010, 2'd1, 1'b1, $sformatf("single_cycle%0d", c));
      @(posedge clk); #1;
      e = sb.pop_front(); n = sb_name.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
        fails++;
        $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                 n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] r [4];
    logic [3:0] g [4];
    logic [1:0] x [4];
    exp_t e; string n;
    r[0] = 4'b1000; g[0] = 4'b1000; x[0] = 2'd3;
    r[1] = 4'b1001; g[1] = 4'b1000; x[1] = 2'd3;
    r[2] = 4'b1001; g[2] = 4'b1000; x[2] = 2'd3;
    r[3] = 4'b0001; g[3] = 4'b0001; x[3] = 2'd0;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req = r[k];
      push(g[k], x[k], 1'b1, $sformatf("wrap_step%0d", k));
      @(posedge clk); #1;
      e = sb.pop_front(); n = sb_name.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
        fails++;
        $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                 n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  // Owner 1 held 8 cycles; on the 8th edge it releases while the limit is also hit.
  task automatic test_release_timeout();
    exp_t e; string n;
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.req = (c == 0) ? 4'b0010 : ((c < 8) ? 4'b1110 : 4'b1100);
      if (c < 8) push(4'b0010, 2'd1, 1'b1, $sformatf("reltmo_hold%0d", c));
      else       push(4'b0100, 2'd2, 1'b1, "reltmo_next");
      @(posedge clk); #1;
      e = sb.pop_front(); n = sb_name.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
        fails++;
        $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                 n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e; string n;
    reset_dut();
    #1 bus.req = 4'b0001;
    #2 bus.req = 4'b0000;
    push(4'b0000, 2'd0, 1'b0, "glitch_ignored");
    @(posedge clk); #1;
    e = sb.pop_front(); n = sb_name.pop_front();
    tests++;
    if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
      fails++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
               n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
    end
  endtask

  task automatic test_reset_mid_grant();
    exp_t e; string n;
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0, 1: begin
          @(negedge clk);
          bus.req = 4'b0100;
          push(4'b0100, 2'd2, 1'b1, $sformatf("midrst_owner%0d", c));
          @(posedge clk); #1;
        end
        2: begin
          @(negedge clk);
          #2 rst = 1'b1;
          push(4'b0000, 2'd0, 1'b0, "midrst_async_clear");
          #1;
        end
        default: begin
          bus.req = 4'b1111;
          @(negedge clk);
          rst = 1'b0;
          push(4'b0001, 2'd0, 1'b1, "midrst_restart_client0");
          @(posedge clk); #1;
        end
      endcase
      e = sb.pop_front(); n = sb_name.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_vld !== e.vld) begin
        fails++;
        $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                 n, bus.gnt, bus.gnt_idx, bus.gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    rst = 1'b1;
    test_reset();
    test_basic_handover();
    test_rotation();
    test_single_requester();
    test_wrap();
    test_release_timeout();
    test_glitch();
    test_reset_mid_grant();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
